// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider: (2N-1)-bit dividend / N-bit divisor,
// one quotient bit per clock, MSB first, with start/busy/done handshake.
module divisor_secuencial #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-2:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [2*N-2:0] Cociente,
    output logic [N-1:0]   Residuo,
    output logic           busy,
    output logic           done,
    output logic           div_cero
);

    localparam int unsigned W  = 2 * N - 1;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state, w_state;
    logic [W-1:0]   r_dvd, w_dvd;
    logic [N-1:0]   r_dvs, w_dvs;
    // Restored remainder is always below the divisor, so N bits hold it between iterations.
    logic [N-1:0]   r_rem, w_rem;
    logic [W-1:0]   r_q, w_q;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [W-1:0]   r_coc, w_coc;
    logic [N-1:0]   r_res, w_res;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_dz, w_dz;

    logic [N:0]     w_shift;
    logic [N:0]     w_sub;
    logic           w_ge;

    // One restoring step: shift in the next dividend bit, compare and subtract in N+1 bits.
    always_comb begin
        w_shift = {r_rem, r_dvd[r_cnt]};
        w_ge    = (w_shift >= {1'b0, r_dvs});
        w_sub   = w_shift - {1'b0, r_dvs};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_coc   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_dvd   <= w_dvd;
            r_dvs   <= w_dvs;
            r_rem   <= w_rem;
            r_q     <= w_q;
            r_cnt   <= w_cnt;
            r_coc   <= w_coc;
            r_res   <= w_res;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_dz    <= w_dz;
        end
    end

    always_comb begin
        w_state = r_state;
        w_dvd   = r_dvd;
        w_dvs   = r_dvs;
        w_rem   = r_rem;
        w_q     = r_q;
        w_cnt   = r_cnt;
        w_coc   = r_coc;
        w_res   = r_res;
        w_dz    = r_dz;
        w_busy  = 1'b0;
        w_done  = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                w_state = IDLE;
                if (start) begin
                    if (Divisor != '0) begin
                        w_dvd   = Dividendo;
                        w_dvs   = Divisor;
                        w_rem   = '0;
                        w_q     = '0;
                        w_cnt   = CW'(W - 1);
                        w_dz    = 1'b0;
                        w_state = CALC;
                    end else begin
                        // Divide by zero completes immediately with a saturated quotient.
                        w_coc   = '1;
                        w_res   = '0;
                        w_dz    = 1'b1;
                        w_state = DONE;
                    end
                end
            end
            CALC: begin
                w_rem        = w_ge ? w_sub[N-1:0] : w_shift[N-1:0];
                w_q[r_cnt]   = w_ge;
                if (r_cnt == '0) begin
                    w_coc   = w_q;
                    w_res   = w_rem;
                    w_state = DONE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        w_busy = (w_state == CALC);
        w_done = (w_state == DONE);
    end

    assign Cociente = r_coc;
    assign Residuo  = r_res;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_cero = r_dz;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial (N=8): expected quotient/remainder
// are queued when a start is accepted and compared when done pulses.
module tb_divisor_secuencial;

    localparam int unsigned N = 8;
    localparam int unsigned W = 2 * N - 1;
    localparam int MAX_WAIT = 40;

    typedef struct {
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] Dividendo;
    logic [N-1:0] Divisor;
    logic [W-1:0] Cociente;
    logic [N-1:0] Residuo;
    logic         busy;
    logic         done;
    logic         div_cero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    divisor_secuencial #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .Dividendo(Dividendo),
        .Divisor  (Divisor),
        .Cociente (Cociente),
        .Residuo  (Residuo),
        .busy     (busy),
        .done     (done),
        .div_cero (div_cero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at #1 after the sampling edge. Queues the
    // expected result only when the bench knows the request will be accepted.
    task automatic start_op(input logic [W-1:0] a, input logic [N-1:0] b, input bit push);
        exp_t e;
        start     = 1'b1;
        Dividendo = a;
        Divisor   = b;
        if (push) begin
            if (b == '0) begin
                e.q  = {W{1'b1}};
                e.r  = '0;
                e.dz = 1'b1;
            end else begin
                e.q  = W'(a / W'(b));
                e.r  = N'(a % W'(b));
                e.dz = 1'b0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done; also counts busy cycles seen.
    task automatic wait_done(output int lat, output int busy_cyc, output bit timeout);
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        Dividendo = '0;
        Divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({Cociente, Residuo, busy, done, div_cero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
                     Cociente, Residuo, busy, done, div_cero);
        end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({Cociente, Residuo, busy, done, div_cero} !== '0) begin
            errors++;
            $display("FAIL idle_hold: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
                     Cociente, Residuo, busy, done, div_cero);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        bit to;
        exp_t e;
        start_op(15'd1000, 8'd7, 1'b1);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL basic_timeout: done not seen within %0d cycles", MAX_WAIT);
        end
        checks++;
        if (lat !== W || bc !== W) begin
            errors++;
            $display("FAIL basic_latency: got lat=%0d busy=%0d, want %0d and %0d", lat, bc, W, W);
        end
        checks++;
        if (Cociente !== e.q || Residuo !== e.r || div_cero !== e.dz || e.q !== 15'd142 || e.r !== 8'd6) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want q=142 r=6 dz=0",
                     Cociente, Residuo, div_cero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Cociente !== 15'd142 || Residuo !== 8'd6) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b q=%0d r=%0d, want 0 0 142 6",
                     done, busy, Cociente, Residuo);
        end
    endtask

    task automatic test_bounds();
        logic [W-1:0] a_tab [2];
        logic [N-1:0] b_tab [2];
        int lat, bc;
        bit to;
        exp_t e;
        a_tab[0] = 15'd32767; b_tab[0] = 8'd1;
        a_tab[1] = 15'd5;     b_tab[1] = 8'd9;
        for (int i = 0; i < 2; i++) begin
            start_op(a_tab[i], b_tab[i], 1'b1);
            wait_done(lat, bc, to);
            e = sb.pop_front();
            checks++;
            if (to || Cociente !== e.q || Residuo !== e.r || div_cero !== 1'b0) begin
                errors++;
                $display("FAIL bounds_%0d: got q=%0d r=%0d dz=%b to=%b, want q=%0d r=%0d dz=0",
                         i, Cociente, Residuo, div_cero, to, e.q, e.r);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        bit to;
        exp_t e;
        @(posedge clk);
        #1;
        start_op(15'd123, 8'd0, 1'b1);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL divzero_latency: got lat=%0d busy=%0d to=%b, want 0 0 0", lat, bc, to);
        end
        checks++;
        if (Cociente !== 15'h7FFF || Residuo !== 8'd0 || div_cero !== 1'b1 || e.dz !== 1'b1) begin
            errors++;
            $display("FAIL divzero_result: got q=%h r=%0d dz=%b, want 7fff 0 1",
                     Cociente, Residuo, div_cero);
        end
        // Next accepted nonzero divisor clears the flag.
        start_op(15'd50, 8'd5, 1'b1);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || Cociente !== e.q || Residuo !== e.r || div_cero !== 1'b0) begin
            errors++;
            $display("FAIL divzero_clear: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                     Cociente, Residuo, div_cero, e.q, e.r);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        bit to;
        exp_t e;
        logic [W-1:0] prev_q;
        prev_q = Cociente;
        start_op(15'd1000, 8'd7, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || Cociente !== prev_q) begin
            errors++;
            $display("FAIL calc_hold: got busy=%b q=%0d, want busy=1 q=%0d", busy, Cociente, prev_q);
        end
        start_op(15'd200, 8'd3, 1'b0);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || lat + 5 !== W || Cociente !== e.q || Residuo !== e.r) begin
            errors++;
            $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want q=142 r=6 lat=%0d",
                     Cociente, Residuo, lat, W - 5);
        end
        @(posedge clk);
        #1;
        start_op(15'd200, 8'd3, 1'b1);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || Cociente !== 15'd66 || Residuo !== 8'd2 || e.q !== 15'd66) begin
            errors++;
            $display("FAIL after_ignore: got q=%0d r=%0d, want q=66 r=2", Cociente, Residuo);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit to;
        exp_t e;
        start_op(15'd1000, 8'd7, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({Cociente, Residuo, busy, done, div_cero} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got q=%0d r=%0d busy=%b done=%b dz=%b, want all 0",
                     Cociente, Residuo, busy, done, div_cero);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_op(15'd255, 8'd16, 1'b1);
        wait_done(lat, bc, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== W || Cociente !== 15'd15 || Residuo !== 8'd15 || e.r !== 8'd15) begin
            errors++;
            $display("FAIL post_reset: got q=%0d r=%0d lat=%0d, want q=15 r=15 lat=%0d",
                     Cociente, Residuo, lat, W);
        end
    endtask

    // Random vectors, each new start issued in the DONE cycle of the previous one.
    task automatic test_back_to_back();
        int lat, bc;
        bit to;
        exp_t e;
        logic [W-1:0] a;
        logic [N-1:0] b;
        int bad = 0;
        for (int i = 0; i < 500; i++) begin
            a = W'($urandom);
            b = N'($urandom);
            if (i % 50 == 7) b = '0;
            start_op(a, b, 1'b1);
            wait_done(lat, bc, to);
            e = sb.pop_front();
            checks++;
            if (to || Cociente !== e.q || Residuo !== e.r || div_cero !== e.dz) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d dz=%b to=%b, want q=%0d r=%0d dz=%b",
                             i, a, b, Cociente, Residuo, div_cero, to, e.q, e.r, e.dz);
                bad++;
                if (to) break;
            end
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
